// File: rtl/sseg_dev_pkg.sv
// Shared constants for the eight-digit serial seven-segment driver.
package sseg_dev_pkg;

  localparam int FRAME_BITS = 64;
  localparam int BIT_W      = $clog2(FRAME_BITS);

  // Active-high gfedcba patterns, entry 15 (F) first.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } sseg_state_e;

  function automatic logic [6:0] hex_seg(input logic [3:0] nibble);
    return HEX_SEG[nibble];
  endfunction

endpackage

// File: rtl/sseg_hex_decode.sv
// One digit: hex nibble plus dp/blank controls to an active-low {dp,g..a} byte.
module sseg_hex_decode (
  input  logic [3:0] nibble,
  input  logic       dp_on,
  input  logic       blank,
  output logic [7:0] seg_n
);
  import sseg_dev_pkg::*;

  always_comb begin
    seg_n = 8'hFF;
    if (!blank) begin
      seg_n = ~{dp_on, hex_seg(nibble)};
    end
  end

endmodule

// File: rtl/sseg_dev.sv
// Serial driver for the 8-digit display chain: one 64-bit frame per Start edge.
//
// state    | meaning
// ST_IDLE  | waiting for a synchronised Start edge, SEG_PEN=1, seg_clk low
// ST_SHIFT | clocking the captured frame out MSB first, SEG_PEN=0
module sseg_dev #(
  parameter int HALF_PER = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        Start,
  input  logic        flash,
  input  logic [31:0] Hexs,
  input  logic [7:0]  point,
  input  logic [7:0]  LES,
  output logic        seg_clk,
  output logic        seg_clrn,
  output logic        seg_sout,
  output logic        SEG_PEN
);
  import sseg_dev_pkg::*;

  localparam int               PHASE_W      = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;
  localparam logic [PHASE_W-1:0] PHASE_RELOAD = PHASE_W'(HALF_PER - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST     = BIT_W'(FRAME_BITS - 1);

  logic [FRAME_BITS-1:0] frame_w;

  for (genvar i = 0; i < 8; i++) begin : g_digit
    sseg_hex_decode u_dec (
      .nibble (Hexs[4*i +: 4]),
      .dp_on  (point[i]),
      .blank  (flash & LES[i]),
      .seg_n  (frame_w[8*i +: 8])
    );
  end

  sseg_state_e           state_q, state_d;
  logic                  start_meta_q, start_sync_q, start_prev_q;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [PHASE_W-1:0]    phase_q, phase_d;
  logic                  hi_q, hi_d;
  logic                  seg_clk_q, seg_clk_d;
  logic                  seg_sout_q, seg_sout_d;
  logic                  seg_pen_q, seg_pen_d;
  logic                  seg_clrn_q;
  logic                  start_edge;

  assign start_edge = start_sync_q & ~start_prev_q;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    phase_d    = phase_q;
    hi_d       = hi_q;
    seg_clk_d  = seg_clk_q;
    seg_sout_d = seg_sout_q;
    seg_pen_d  = seg_pen_q;
    unique case (state_q)
      ST_IDLE: begin
        seg_clk_d = 1'b0;
        seg_pen_d = 1'b1;
        if (start_edge) begin
          state_d    = ST_SHIFT;
          shreg_d    = frame_w;
          seg_sout_d = frame_w[FRAME_BITS-1];
          bit_cnt_d  = BIT_LAST;
          phase_d    = PHASE_RELOAD;
          hi_d       = 1'b0;
          seg_pen_d  = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (phase_q != '0) begin
          phase_d = phase_q - 1'b1;
        end else if (!hi_q) begin
          hi_d      = 1'b1;
          seg_clk_d = 1'b1;
          phase_d   = PHASE_RELOAD;
        end else if (bit_cnt_q == '0) begin
          state_d   = ST_IDLE;
          seg_clk_d = 1'b0;
          seg_pen_d = 1'b1;
          hi_d      = 1'b0;
        end else begin
          // Data and the falling clock move together so sout never changes while high.
          shreg_d    = shreg_q << 1;
          seg_sout_d = shreg_d[FRAME_BITS-1];
          bit_cnt_d  = bit_cnt_q - 1'b1;
          phase_d    = PHASE_RELOAD;
          hi_d       = 1'b0;
          seg_clk_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      start_meta_q <= 1'b0;
      start_sync_q <= 1'b0;
      start_prev_q <= 1'b0;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      phase_q      <= '0;
      hi_q         <= 1'b0;
      seg_clk_q    <= 1'b0;
      seg_sout_q   <= 1'b0;
      seg_pen_q    <= 1'b0;
      seg_clrn_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_meta_q <= Start;
      start_sync_q <= start_meta_q;
      start_prev_q <= start_sync_q;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      phase_q      <= phase_d;
      hi_q         <= hi_d;
      seg_clk_q    <= seg_clk_d;
      seg_sout_q   <= seg_sout_d;
      seg_pen_q    <= seg_pen_d;
      seg_clrn_q   <= 1'b1;
    end
  end

  assign seg_clk  = seg_clk_q;
  assign seg_sout = seg_sout_q;
  assign SEG_PEN  = seg_pen_q;
  assign seg_clrn = seg_clrn_q;

endmodule

// File: tb/tb_sseg_dev.sv
// Directed bench for sseg_dev: captures the serial frame at seg_clk rising edges.
module tb_sseg_dev;

  logic        clk = 1'b0;
  logic        rstn;
  logic        Start;
  logic        flash;
  logic [31:0] Hexs;
  logic [7:0]  point;
  logic [7:0]  LES;
  logic        seg_clk, seg_clrn, seg_sout, SEG_PEN;

  int checks = 0;
  int errors = 0;

  logic [63:0] cap_bits;
  int          cap_edges, cap_low, cap_bad;
  logic        cap_to;

  sseg_dev #(.HALF_PER(2)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .Start    (Start),
    .flash    (flash),
    .Hexs     (Hexs),
    .point    (point),
    .LES      (LES),
    .seg_clk  (seg_clk),
    .seg_clrn (seg_clrn),
    .seg_sout (seg_sout),
    .SEG_PEN  (SEG_PEN)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_pulse(input int hold);
    @(negedge clk);
    Start = 1'b1;
    repeat (hold) @(negedge clk);
    Start = 1'b0;
  endtask

  // Waits for SEG_PEN to drop, then records bits until it rises again.
  task automatic capture();
    int   n;
    logic prev_clk, prev_sout;
    cap_bits = '0; cap_edges = 0; cap_low = 0; cap_bad = 0; cap_to = 1'b0;
    n = 0;
    @(negedge clk);
    while (SEG_PEN !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      cap_to = 1'b1;
    end else begin
      prev_clk  = 1'b0;
      prev_sout = seg_sout;
      while (SEG_PEN === 1'b0 && cap_low < 2000) begin
        cap_low++;
        if (seg_clk === 1'b1 && prev_clk === 1'b0) begin
          cap_bits = {cap_bits[62:0], seg_sout};
          cap_edges++;
        end
        if (seg_clk === 1'b1 && seg_sout !== prev_sout) cap_bad++;
        prev_clk  = seg_clk;
        prev_sout = seg_sout;
        @(negedge clk);
      end
      if (cap_low >= 2000) cap_to = 1'b1;
    end
  endtask

  task automatic check_frame(input string tag, input logic [63:0] exp);
    check({tag, "_timeout"}, 64'(cap_to), 64'd0);
    check({tag, "_bits"}, cap_bits, exp);
    check({tag, "_edges"}, 64'(cap_edges), 64'd64);
    check({tag, "_len"}, 64'(cap_low), 64'd256);
    check({tag, "_sout_stable"}, 64'(cap_bad), 64'd0);
    check({tag, "_pen_after"}, 64'(SEG_PEN), 64'd1);
  endtask

  task automatic idle_watch(input int n, output int act);
    act = 0;
    repeat (n) begin
      @(negedge clk);
      if (seg_clk !== 1'b0 || SEG_PEN !== 1'b1 || seg_clrn !== 1'b1) act++;
    end
  endtask

  initial begin
    int act, n, edges;
    logic prevc;

    rstn = 1'b1; Start = 1'b0; flash = 1'b0;
    Hexs = 32'h0000_0003; point = 8'h00; LES = 8'h00;
    #2 rstn = 1'b0;
    #1;
    check("rst_clk",  64'(seg_clk),  64'd0);
    check("rst_sout", 64'(seg_sout), 64'd0);
    check("rst_pen",  64'(SEG_PEN),  64'd0);
    check("rst_clrn", 64'(seg_clrn), 64'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("rel_clrn", 64'(seg_clrn), 64'd1);
    check("rel_pen",  64'(SEG_PEN),  64'd1);

    fork start_pulse(3); capture(); join
    check_frame("f_three", 64'hC0C0_C0C0_C0C0_C0B0);

    Hexs = 32'h0A00_0005; point = 8'b0100_0001;
    fork start_pulse(3); capture(); join
    check_frame("f_a5dp", 64'hC008_C0C0_C0C0_C012);

    point = 8'h80; LES = 8'h80; flash = 1'b1;
    fork start_pulse(3); capture(); join
    check_frame("f_blank", 64'hFF88_C0C0_C0C0_C092);
    check("blank_first_byte", 64'(cap_bits[63:56]), 64'hFF);
    flash = 1'b0;
    fork start_pulse(3); capture(); join
    check_frame("f_noblank", 64'h4088_C0C0_C0C0_C092);

    point = 8'h00; LES = 8'h00; Hexs = 32'h89AB_CDEF;
    fork
      start_pulse(3);
      capture();
      begin
        repeat (100) @(negedge clk);
        Start = 1'b1;
        repeat (3) @(negedge clk);
        Start = 1'b0;
      end
    join
    check_frame("f_midstart", 64'h8090_8883_C6A1_868E);
    idle_watch(40, act);
    check("midstart_dropped", 64'(act), 64'd0);

    Hexs = 32'h1234_5670;
    @(negedge clk);
    Start = 1'b1;
    capture();
    check_frame("f_held", 64'hF9A4_B099_9282_F8C0);
    idle_watch(300, act);
    check("held_single_frame", 64'(act), 64'd0);
    Start = 1'b0;
    idle_watch(10, act);

    start_pulse(3);
    edges = 0; n = 0; prevc = 1'b0;
    while (edges < 30 && n < 1000) begin
      @(negedge clk);
      if (seg_clk === 1'b1 && prevc === 1'b0) edges++;
      prevc = seg_clk;
      n++;
    end
    check("abort_reach_bit30", 64'(edges), 64'd30);
    #1 rstn = 1'b0;
    #1;
    check("abort_clk",  64'(seg_clk),  64'd0);
    check("abort_sout", 64'(seg_sout), 64'd0);
    check("abort_pen",  64'(SEG_PEN),  64'd0);
    check("abort_clrn", 64'(seg_clrn), 64'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    idle_watch(60, act);
    check("abort_no_resume", 64'(act), 64'd0);
    fork start_pulse(3); capture(); join
    check_frame("f_after_abort", 64'hF9A4_B099_9282_F8C0);

    Hexs = 32'h89AB_CDEF;
    fork
      start_pulse(3);
      capture();
      begin
        n = 0;
        @(negedge clk);
        while (SEG_PEN !== 1'b0 && n < 50) begin
          @(negedge clk);
          n++;
        end
        Hexs = 32'h0000_0000;
        point = 8'hFF;
      end
    join
    check_frame("f_late_hexs", 64'h8090_8883_C6A1_868E);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
